// File: rtl/alu_result_checker.sv
// alu_result_checker: self-checking consumer at the ALU32bit result end.
// Builds the golden {R,Z,N,C,V} for each accepted {op,A,B} vector and delays it
// LATENCY cycles. It compares the delayed value against the live ALU outputs and
// keeps saturating pass/fail counts plus a sticky error.
// LATENCY must be >= 1.
// Optional feature macro: ALU_CHK_CAPTURE_EN. When it is defined, the checker
// latches the first failing vector on the cap_* outputs.
//
// state  | meaning
// S_RUN  | accepting vectors, comparing pipe outputs
// S_HALT | a mismatch was seen with STOP_ON_FAIL=1; no accepts, pipe drains

module alu_result_checker #(
  parameter int LATENCY      = 1,
  parameter int CNT_W        = 16,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             chk_valid,
  output logic             chk_ready,
  input  logic [1:0]       chk_op,
  input  logic [31:0]      chk_a,
  input  logic [31:0]      chk_b,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_negative,
  input  logic             alu_carryout,
  input  logic             alu_overflow,
  output logic             cmp_valid,
  output logic             cmp_pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             error,
  output logic             halted
`ifdef ALU_CHK_CAPTURE_EN
  ,
  output logic [1:0]       cap_op,
  output logic [31:0]      cap_a,
  output logic [31:0]      cap_b,
  output logic [31:0]      cap_exp,
  output logic [31:0]      cap_got
`endif
);

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t state_q, state_d;

  logic               accept;
  logic [35:0]        golden;
  logic [32:0]        sum;
  logic [LATENCY-1:0] pv;
  logic [35:0]        pg [LATENCY];
  logic [35:0]        got;
  logic               due;
  logic               match;
  logic               pass_now;
  logic               fail_now;

  // chk_ready is held low while rst_n is asserted, not just from the next edge.
  assign chk_ready = rst_n & (state_q == S_RUN);
  assign accept    = chk_valid & chk_ready;
  assign halted    = (state_q == S_HALT);

  // Golden model: sub uses A + ~B + 1, so the carry means "no borrow".
  always_comb begin
    sum    = '0;
    golden = '0;
    case (chk_op)
      2'b00: begin
        sum    = {1'b0, chk_a} + {1'b0, chk_b};
        golden = {sum[31:0], (sum[31:0] == 32'd0), sum[31], sum[32],
                  (chk_a[31] == chk_b[31]) && (sum[31] != chk_a[31])};
      end
      2'b01: begin
        sum    = {1'b0, chk_a} + {1'b0, ~chk_b} + 33'd1;
        golden = {sum[31:0], (sum[31:0] == 32'd0), sum[31], sum[32],
                  (chk_a[31] != chk_b[31]) && (sum[31] != chk_a[31])};
      end
      2'b10: begin
        sum[31:0] = chk_a & chk_b;
        golden    = {sum[31:0], (sum[31:0] == 32'd0), sum[31], 2'b00};
      end
      default: begin
        sum[31:0] = chk_a | chk_b;
        golden    = {sum[31:0], (sum[31:0] == 32'd0), sum[31], 2'b00};
      end
    endcase
  end

  // Delay pipe for the golden values; a clear empties it, including any same-edge accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int i = 0; i < LATENCY; i++) pg[i] <= '0;
    end else if (clear) begin
      pv <= '0;
    end else begin
      pv[0] <= accept;
      pg[0] <= golden;
      for (int i = 1; i < LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pg[i] <= pg[i-1];
      end
    end
  end

  assign got      = {alu_result, alu_zero, alu_negative, alu_carryout, alu_overflow};
  assign due      = pv[LATENCY-1];
  assign match    = (got == pg[LATENCY-1]);
  assign pass_now = due & match & ~clear;
  assign fail_now = due & ~match & ~clear;

  // Registered compare result, saturating counters and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_valid <= 1'b0;
      cmp_pass  <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      error     <= 1'b0;
    end else if (clear) begin
      cmp_valid <= 1'b0;
      cmp_pass  <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      error     <= 1'b0;
    end else begin
      cmp_valid <= due;
      cmp_pass  <= due & match;
      if (pass_now && (pass_cnt != {CNT_W{1'b1}})) pass_cnt <= pass_cnt + CNT_W'(1);
      if (fail_now) begin
        error <= 1'b1;
        if (fail_cnt != {CNT_W{1'b1}}) fail_cnt <= fail_cnt + CNT_W'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  // Next state: a fail halts only when STOP_ON_FAIL is set, and only clear leaves HALT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (fail_now && STOP_ON_FAIL) state_d = S_HALT;
      default: state_d = state_q;
    endcase
    if (clear) state_d = S_RUN;
  end

`ifdef ALU_CHK_CAPTURE_EN
  logic [65:0] pc [LATENCY];
  logic        cap_done;

  // Carries op/A/B alongside the golden value so a fail can report its vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) pc[i] <= '0;
    end else begin
      pc[0] <= {chk_op, chk_a, chk_b};
      for (int i = 1; i < LATENCY; i++) pc[i] <= pc[i-1];
    end
  end

  // Latches the first failing vector and holds it until clear or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_done <= 1'b0;
      cap_op   <= '0;
      cap_a    <= '0;
      cap_b    <= '0;
      cap_exp  <= '0;
      cap_got  <= '0;
    end else if (clear) begin
      cap_done <= 1'b0;
      cap_op   <= '0;
      cap_a    <= '0;
      cap_b    <= '0;
      cap_exp  <= '0;
      cap_got  <= '0;
    end else if (fail_now && !cap_done) begin
      cap_done <= 1'b1;
      cap_op   <= pc[LATENCY-1][65:64];
      cap_a    <= pc[LATENCY-1][63:32];
      cap_b    <= pc[LATENCY-1][31:0];
      cap_exp  <= pg[LATENCY-1][35:4];
      cap_got  <= alu_result;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_checker.sv
// Testbench for alu_result_checker. It uses a behavioural ALU with an XOR
// fault mask on its outputs, and a transaction-level model of the checker's
// expected compares and counts.
module tb_alu_result_checker;

  localparam int LATENCY = 1;
  localparam int CNT_W   = 4;
  localparam int MAXC    = (1 << CNT_W) - 1;
  localparam bit STOP    = 1'b1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic             chk_valid;
  logic             chk_ready;
  logic [1:0]       chk_op;
  logic [31:0]      chk_a, chk_b;
  logic [31:0]      alu_result;
  logic             alu_zero, alu_negative, alu_carryout, alu_overflow;
  logic             cmp_valid, cmp_pass;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;
  logic             error, halted;
  logic [35:0]      alu_mask;
`ifdef ALU_CHK_CAPTURE_EN
  logic [1:0]       cap_op;
  logic [31:0]      cap_a, cap_b, cap_exp, cap_got;
`endif

  alu_result_checker #(.LATENCY(LATENCY), .CNT_W(CNT_W), .STOP_ON_FAIL(STOP)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .chk_valid(chk_valid), .chk_ready(chk_ready),
    .chk_op(chk_op), .chk_a(chk_a), .chk_b(chk_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_negative(alu_negative),
    .alu_carryout(alu_carryout), .alu_overflow(alu_overflow),
    .cmp_valid(cmp_valid), .cmp_pass(cmp_pass),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .error(error), .halted(halted)
`ifdef ALU_CHK_CAPTURE_EN
    , .cap_op(cap_op), .cap_a(cap_a), .cap_b(cap_b), .cap_exp(cap_exp), .cap_got(cap_got)
`endif
  );

  always #5 clk = ~clk;

  // Reference ALU built from signed/unsigned arithmetic.
  function automatic logic [35:0] ref_alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb, s, lim;
    logic [31:0] r;
    bit c, v;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    lim = 64'sd2147483648;
    c = 1'b0; v = 1'b0;
    case (op)
      2'd0: begin r = a + b; c = (ua + ub) > 64'sd4294967295; s = sa + sb; v = (s >= lim) || (s < -lim); end
      2'd1: begin r = a - b; c = (ua >= ub); s = sa - sb; v = (s >= lim) || (s < -lim); end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
    return {r, (r == 32'd0), r[31], c, v};
  endfunction

  // Device under check: a one-cycle registered ALU with injectable faults.
  always @(posedge clk)
    {alu_result, alu_zero, alu_negative, alu_carryout, alu_overflow} <= ref_alu(chk_op, chk_a, chk_b) ^ alu_mask;

  typedef struct {int due; bit pass; logic [1:0] op; logic [31:0] a, b, exp, got;} txn_t;
  txn_t q[$];
  int  cyc, n_checks, n_errors;
  int  m_pass, m_fail;
  bit  m_err, m_halt, m_cv, m_cp, m_capd;
  logic [1:0]  m_cop;
  logic [31:0] m_ca, m_cb, m_cexp, m_cgot;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_pass = 0; m_fail = 0; m_err = 0; m_halt = 0; m_cv = 0; m_cp = 0;
    m_capd = 0; m_cop = '0; m_ca = '0; m_cb = '0; m_cexp = '0; m_cgot = '0;
  endtask

  task automatic model_edge();
    txn_t e;
    bit halt_old;
    cyc++;
    if (clear) begin
      model_clear();
    end else begin
      halt_old = m_halt;
      m_cv = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        m_cv = 1; m_cp = e.pass;
        if (e.pass) begin
          if (m_pass < MAXC) m_pass++;
        end else begin
          if (m_fail < MAXC) m_fail++;
          m_err = 1;
          if (STOP) m_halt = 1;
          if (!m_capd) begin
            m_capd = 1; m_cop = e.op; m_ca = e.a; m_cb = e.b; m_cexp = e.exp; m_cgot = e.got;
          end
        end
      end
      if (chk_valid && !halt_old) begin
        e.due = cyc + LATENCY; e.pass = (alu_mask == '0);
        e.op = chk_op; e.a = chk_a; e.b = chk_b;
        e.exp = ref_alu(chk_op, chk_a, chk_b) >> 4;
        e.got = e.exp ^ alu_mask[35:4];
        q.push_back(e);
      end
    end
  endtask

  task automatic check_outputs();
    chk_val("cmp_valid", 64'(cmp_valid), 64'(m_cv));
    if (m_cv) chk_val("cmp_pass", 64'(cmp_pass), 64'(m_cp));
    chk_val("pass_cnt", 64'(pass_cnt), 64'(m_pass));
    chk_val("fail_cnt", 64'(fail_cnt), 64'(m_fail));
    chk_val("error", 64'(error), 64'(m_err));
    chk_val("halted", 64'(halted), 64'(m_halt));
    chk_val("chk_ready", 64'(chk_ready), 64'(!m_halt));
`ifdef ALU_CHK_CAPTURE_EN
    chk_val("cap_op", 64'(cap_op), 64'(m_cop));
    chk_val("cap_a", 64'(cap_a), 64'(m_ca));
    chk_val("cap_b", 64'(cap_b), 64'(m_cb));
    chk_val("cap_exp", 64'(cap_exp), 64'(m_cexp));
    chk_val("cap_got", 64'(cap_got), 64'(m_cgot));
`endif
  endtask

  // One clock: drive inputs (called just after a falling edge), run the model, check.
  task automatic step(input bit v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [35:0] mask, input bit clr);
    chk_valid = v; chk_op = op; chk_a = a; chk_b = b; alu_mask = mask; clear = clr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 32'd0, 32'd0, 36'd0, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    chk_val({tag, "_ready"}, 64'(chk_ready), 64'd0);
    chk_val({tag, "_outs"}, 64'({cmp_valid, cmp_pass, error, halted}), 64'd0);
    chk_val({tag, "_cnts"}, 64'({pass_cnt, fail_cnt}), 64'd0);
  endtask

  task automatic pulse_reset();
    chk_valid = 1'b0; clear = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_state("rst_mid");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_val("ready_after_rst", 64'(chk_ready), 64'd1);
  endtask

  logic [31:0] ra, rb;
  logic [35:0] rm;

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    model_clear();
    rst_n = 1'b0; clear = 1'b0; chk_valid = 1'b0; chk_op = '0; chk_a = '0; chk_b = '0; alu_mask = '0;
    repeat (2) @(negedge clk);
    check_reset_state("rst_init");
    rst_n = 1'b1;
    #1;
    chk_val("ready_after_rst", 64'(chk_ready), 64'd1);

    // Directed arithmetic corners.
    step(1, 2'd0, 32'd6, 32'd0, 36'd0, 0);
    step(1, 2'd1, 32'd5, 32'd5, 36'd0, 0);
    step(1, 2'd0, 32'h7FFF_FFFF, 32'd1, 36'd0, 0);
    step(1, 2'd1, 32'd0, 32'd1, 36'd0, 0);
    step(1, 2'd0, 32'hFFFF_FFFF, 32'd1, 36'd0, 0);
    step(1, 2'd1, 32'h8000_0000, 32'd1, 36'd0, 0);
    idle(2);

    // Eight back-to-back and/or vectors, then clear.
    step(0, 2'd0, 32'd0, 32'd0, 36'd0, 1);
    for (int i = 0; i < 8; i++) step(1, 2'(2 + (i % 2)), $urandom, $urandom, 36'd0, 0);
    idle(2);
    chk_val("b2b_pass_cnt", 64'(pass_cnt), 64'd8);

    // Long passing run saturates pass_cnt.
    for (int i = 0; i < 40; i++) step(($urandom_range(0, 9) < 8), 2'($urandom), $urandom, $urandom, 36'd0, 0);
    idle(2);
    chk_val("pass_sat", 64'(pass_cnt), 64'(MAXC));

    // Forced-zero result on add 3+4 halts; the following entry still drains and counts.
    step(0, 2'd0, 32'd0, 32'd0, 36'd0, 1);
    step(1, 2'd0, 32'd3, 32'd4, {32'd7, 4'd0}, 0);
    step(1, 2'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 36'd0, 0);
    step(1, 2'd3, 32'd1, 32'd2, 36'd0, 0);
    idle(2);
    chk_val("halt_state", 64'({halted, chk_ready, error}), 64'b101);
    step(0, 2'd0, 32'd0, 32'd0, 36'd0, 1);
    idle(1);

    // Clear on the edge where a compare is due; then clear on an accept edge.
    step(1, 2'd0, 32'd10, 32'd20, 36'd0, 0);
    step(0, 2'd0, 32'd0, 32'd0, 36'd0, 1);
    idle(2);
    step(1, 2'd1, 32'd10, 32'd20, 36'd0, 1);
    idle(2);
    chk_val("clear_discard", 64'(pass_cnt), 64'd0);

    // Randomized mix of vectors, occasional faults and clears.
    for (int i = 0; i < 300; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      rm = ($urandom_range(0, 9) == 0) ? (36'd1 << $urandom_range(0, 35)) : 36'd0;
      step(($urandom_range(0, 9) < 8), 2'($urandom), ra, rb, rm, ($urandom_range(0, 19) == 0));
    end

    // Reset with vectors in flight discards them.
    step(0, 2'd0, 32'd0, 32'd0, 36'd0, 1);
    step(1, 2'd0, 32'd1, 32'd2, 36'd0, 0);
    chk_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pulse_reset();
    idle(3);
    chk_val("rst_no_count", 64'({pass_cnt, fail_cnt}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
